vb_encode_scheduler: RTL and testbench
======================================

Name: vb_encode_scheduler

Overview:
- Shares one variable-byte encoder between two requesters. Each requester submits a job of four 8-bit integers.
- Round-robin arbitration picks the next job; the block then starts the encoder, forwards the encoded bytes tagged with the source requester, and reports completion, byte count, or a timeout/overflow error.
- Sits between the board-level job sources (switch/constant operand sets) and the encoder instance.

Parameters:
- TIMEOUT, 64: max cycles without encoder progress (READY change or byte) before abort.
- MAXBYTES, 8: max encoded bytes per job (4 operands x 2 bytes); exceeding it is an error.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- REQ0  in  1  requester 0 job pending (level, held until GNT)
- DATA0  in  32  requester 0 operands: [31:24]=INT4, [23:16]=INT3, [15:8]=INT2, [7:0]=INT1
- REQ1  in  1  requester 1 job pending
- DATA1  in  32  requester 1 operands, same packing
- GNT  out  2  one-hot, one-cycle pulse: job accepted, DATA captured
- DONE  out  2  one-hot, one-cycle pulse: job finished normally
- ERR  out  1  one-cycle pulse: job aborted (timeout or overflow)
- ERR_SRC  out  1  requester of aborted job, valid with ERR
- ENC_START  out  1  one-cycle start pulse to encoder
- ENC_DATA  out  32  captured operands, stable from GNT until job end
- ENC_READY  in  1  encoder idle (high) / busy (low)
- ENC_BYTE  in  8  encoder output byte
- ENC_BVALID  in  1  ENC_BYTE valid this cycle
- OUT_BYTE  out  8  forwarded byte
- OUT_VALID  out  1  OUT_BYTE valid
- OUT_SRC  out  1  requester owning OUT_BYTE
- BYTE_COUNT  out  4  bytes of last completed job, updated with DONE
- BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low at edge): state IDLE; all outputs 0; ENC_DATA 0; round-robin pointer LAST=1, so requester 0 wins first; internal counters 0.
- States: IDLE, START, WAIT_ACK, RUN, FINISH, ABORT.
- IDLE:
  - Only if ENC_READY=1 and any REQ is high: grant the requester not equal to LAST if it requests, else the one requesting.
  - On grant: GNT[id]=1 next cycle, DATA latched into ENC_DATA, LAST<=id, go START.
  - If ENC_READY=0, no grant.
- START: ENC_START=1 for exactly this cycle; timeout counter cleared; go WAIT_ACK.
- WAIT_ACK:
  - ENC_READY=0 -> RUN.
  - ENC_BVALID here is accepted and forwarded as in RUN.
  - Timeout counter reaching TIMEOUT-1 -> ABORT.
- RUN:
  - Each ENC_BVALID: OUT_BYTE<=ENC_BYTE, OUT_VALID<=1, OUT_SRC<=id (1-cycle latency); byte counter +1; timeout counter cleared.
  - ENC_READY=1 -> FINISH; a byte arriving in that same cycle is still forwarded and counted.
  - Counter would exceed MAXBYTES -> ABORT; the offending byte is not forwarded.
  - Timeout -> ABORT.
- FINISH: DONE[id]=1, BYTE_COUNT<=counter, counter cleared, go IDLE. Earliest next GNT is the cycle after IDLE is re-entered.
- ABORT: ERR=1, ERR_SRC=id, BYTE_COUNT unchanged, no DONE, counters cleared, go IDLE. Requester must re-assert REQ to retry.
- REQ deasserted after GNT has no effect on the running job.
- OUT_VALID is never asserted outside WAIT_ACK/RUN/FINISH-entry forwarding; ENC_BVALID in IDLE is ignored.
- rst_n low in any state aborts immediately with no ERR/DONE; ENC_START low from the reset edge.
- Counters saturate-free: the byte counter is 4 bits, sized for MAXBYTES<=15; the timeout counter uses clog2(TIMEOUT) bits.

Test Plan:
- REQ0=1, DATA0=32'h00_66_66_05; encoder emits 4 bytes then READY=1 -> GNT=2'b01, one ENC_START pulse, 4 OUT_VALID pulses with OUT_SRC=0 one cycle after each BVALID, DONE=2'b01, BYTE_COUNT=4.
- REQ0 and REQ1 held high for 3 jobs after reset -> grant order 0,1,0; never two GNTs without an intervening DONE or ERR.
- Encoder never drops READY after START, TIMEOUT=64 -> ERR pulse exactly 64 cycles after START, ERR_SRC=id, no DONE, BUSY low next cycle.
- Encoder emits 9 bytes -> 8 forwarded, ERR on the 9th, BYTE_COUNT keeps its previous value.
- Last ENC_BVALID in the same cycle READY rises -> byte forwarded, counted in BYTE_COUNT, DONE the following cycle.
- rst_n low during RUN after 2 bytes -> next cycle all outputs 0, state IDLE; a following REQ1 gets GNT=2'b10 only if REQ0 is low, since LAST resets to 1.

Source files
------------

// File: rtl/vb_encode_scheduler_if.sv
// vb_encode_scheduler_if: job/encoder/output bundle for the variable-byte encode scheduler.
// Ports (signals):
//   req0/req1, data0/data1  : requester job pending levels and packed operands
//   gnt, done, err, err_src : job accept / normal finish / abort pulses
//   enc_start, enc_data     : encoder start pulse and captured operands
//   enc_ready, enc_byte, enc_bvalid : encoder status and byte stream
//   out_byte, out_valid, out_src    : forwarded byte tagged with its requester
//   byte_count, busy        : bytes of last completed job, scheduler not idle
// master = scheduler side, slave = requesters + encoder + byte sink.
interface vb_encode_scheduler_if;
    logic        req0;
    logic [31:0] data0;
    logic        req1;
    logic [31:0] data1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        err_src;
    logic        enc_start;
    logic [31:0] enc_data;
    logic        enc_ready;
    logic [7:0]  enc_byte;
    logic        enc_bvalid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_src;
    logic [3:0]  byte_count;
    logic        busy;
    modport master (
        input  req0, data0, req1, data1, enc_ready, enc_byte, enc_bvalid,
        output gnt, done, err, err_src, enc_start, enc_data,
               out_byte, out_valid, out_src, byte_count, busy
    );
    modport slave (
        output req0, data0, req1, data1, enc_ready, enc_byte, enc_bvalid,
        input  gnt, done, err, err_src, enc_start, enc_data,
               out_byte, out_valid, out_src, byte_count, busy
    );
endinterface

// File: rtl/vb_encode_scheduler.sv
// vb_encode_scheduler: round-robin sharing of one variable-byte encoder between two requesters.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vb_encode_scheduler_if.master (requests, encoder handshake, forwarded bytes, status)
module vb_encode_scheduler #(
    parameter int TIMEOUT  = 64,
    parameter int MAXBYTES = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    vb_encode_scheduler_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] FINISH   = 3'd4;
    localparam logic [2:0] ABORT    = 3'd5;
    logic [2:0]    state_q, state_d;
    logic          last_q, last_d, id_q, id_d;
    logic [31:0]   enc_data_q, enc_data_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [3:0]    cnt_q, cnt_d, bc_q, bc_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_nx;
    logic [7:0]    ob_q, ob_d;
    logic          ov_q, ov_d, os_q, os_d;
    logic          pick, active, ovf, fwd, tmo_hit;
    always_comb begin
        // requester other than the last winner gets priority when it asks
        pick       = last_q ? !bus.req0 : bus.req1;
        active     = (state_q == WAIT_ACK) || (state_q == RUN);
        ovf        = active && bus.enc_bvalid && (cnt_q == 4'(MAXBYTES));
        fwd        = active && bus.enc_bvalid && !ovf;
        tmo_nx     = tmo_q + 1'b1;
        // abort the moment the no-progress counter would reach TIMEOUT-1
        tmo_hit    = !bus.enc_bvalid && (tmo_nx == TW'(TIMEOUT - 1));
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        enc_data_d = enc_data_q;
        gnt_d      = 2'b00;
        cnt_d      = fwd ? cnt_q + 4'd1 : cnt_q;
        bc_d       = bc_q;
        tmo_d      = bus.enc_bvalid ? '0 : tmo_nx;
        ob_d       = fwd ? bus.enc_byte : ob_q;
        ov_d       = fwd;
        os_d       = fwd ? id_q : os_q;
        case (state_q)
            IDLE: if (bus.enc_ready && (bus.req0 || bus.req1)) begin
                gnt_d      = pick ? 2'b10 : 2'b01;
                enc_data_d = pick ? bus.data1 : bus.data0;
                last_d     = pick;
                id_d       = pick;
                state_d    = START;
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                state_d = ovf ? ABORT : !bus.enc_ready ? RUN : tmo_hit ? ABORT : WAIT_ACK;
                if (!bus.enc_ready) tmo_d = '0;
            end
            RUN: begin
                state_d = ovf ? ABORT : bus.enc_ready ? FINISH : tmo_hit ? ABORT : RUN;
                if (!ovf && bus.enc_ready) bc_d = cnt_d;
            end
            FINISH, ABORT: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            enc_data_q <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            bc_q       <= '0;
            tmo_q      <= '0;
            ob_q       <= '0;
            ov_q       <= 1'b0;
            os_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            enc_data_q <= enc_data_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            bc_q       <= bc_d;
            tmo_q      <= tmo_d;
            ob_q       <= ob_d;
            ov_q       <= ov_d;
            os_q       <= os_d;
        end
    end
    assign bus.gnt        = gnt_q;
    assign bus.done       = (state_q == FINISH) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.err        = state_q == ABORT;
    assign bus.err_src    = (state_q == ABORT) && id_q;
    assign bus.enc_start  = state_q == START;
    assign bus.enc_data   = enc_data_q;
    assign bus.out_byte   = ob_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_src    = os_q;
    assign bus.byte_count = bc_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_vb_encode_scheduler.sv
// tb_vb_encode_scheduler: scenario tasks with a byte scoreboard for vb_encode_scheduler.
module tb_vb_encode_scheduler;
    localparam int MAXB = 8;
    logic clk = 0;
    logic rst_n = 0;
    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int dbl_cnt = 0;
    bit outst = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    vb_encode_scheduler_if bus();
    vb_encode_scheduler #(.TIMEOUT(64), .MAXBYTES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.out_valid) obs_q.push_back({bus.out_src, bus.out_byte});
        if (bus.enc_start) start_cnt++;
        if (bus.done != 2'b00) done_cnt++;
        if (!rst_n) outst = 0;
        else begin
            if (bus.gnt != 2'b00) begin
                if (outst) dbl_cnt++;
                outst = 1;
            end
            if (bus.done != 2'b00 || bus.err) outst = 0;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic do_reset();
        rst_n = 0;
        bus.req0 = 0; bus.req1 = 0; bus.enc_ready = 1; bus.enc_bvalid = 0; bus.enc_byte = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask
    task automatic do_job(input int n, input bit same, input bit drop, output logic [1:0] g,
                          output logic [31:0] d, output logic [1:0] dn, output logic e, output logic [3:0] bc);
        logic [7:0] b;
        g = 0; d = 0; dn = 0; e = 0; bc = 0;
        for (int k = 0; k < 20 && g == 2'b00; k++) begin
            @(negedge clk);
            g = bus.gnt;
            d = bus.enc_data;
        end
        if (g == 2'b00) return;
        @(posedge clk); #1;
        bus.enc_ready = 0;
        if (drop) begin bus.req0 = 0; bus.req1 = 0; end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            b = 8'($urandom_range(0, 255));
            bus.enc_bvalid = 1;
            bus.enc_byte = b;
            if (same && i == n - 1) bus.enc_ready = 1;
            if (i < MAXB) exp_q.push_back({g[1], b});
        end
        @(posedge clk); #1;
        bus.enc_bvalid = 0;
        bus.enc_ready = 1;
        for (int k = 0; k < 20 && dn == 2'b00 && !e; k++) begin
            @(negedge clk);
            dn = bus.done;
            e = bus.err;
            bc = bus.byte_count;
        end
        @(negedge clk);
    endtask
    task automatic test_reset();
        logic [53:0] snap;
        do_reset();
        @(negedge clk);
        snap = {bus.gnt, bus.done, bus.err, bus.err_src, bus.enc_start, bus.enc_data, bus.out_byte,
                bus.out_valid, bus.out_src, bus.byte_count, bus.busy};
        total++; if (snap !== 54'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", snap); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 bus.enc_bvalid = 1; bus.enc_byte = 8'hA5;
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_bvalid got=%b exp=0", bus.out_valid); end
        end
        @(posedge clk); #1 bus.enc_bvalid = 0; bus.enc_ready = 0; bus.req0 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin bad++; $display("FAIL not_ready_gnt got=%b/%b exp=00/0", bus.gnt, bus.busy); end
        end
        @(posedge clk); #1 bus.req0 = 0; bus.enc_ready = 1;
        @(negedge clk); @(negedge clk);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_forward got=%0d exp=0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask
    task automatic test_single();
        logic [1:0] g, dn; logic [31:0] d; logic e; logic [3:0] bc; logic [8:0] o9, e9; int s0;
        do_reset();
        s0 = start_cnt;
        bus.data0 = 32'h00666605; bus.req0 = 1;
        do_job(4, 0, 1, g, d, dn, e, bc);
        total++; if (g !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b exp=01", g); end
        total++; if (d !== 32'h00666605) begin bad++; $display("FAIL single_data got=%h exp=00666605", d); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start got=%0d exp=1", start_cnt - s0); end
        total++; if (dn !== 2'b01 || e !== 1'b0) begin bad++; $display("FAIL single_done got=%b/%b exp=01/0", dn, e); end
        total++; if (bc !== 4'd4) begin bad++; $display("FAIL single_count got=%0d exp=4", bc); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_nbytes got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e9 = exp_q.pop_front(); o9 = obs_q.pop_front();
            total++; if (o9 !== e9) begin bad++; $display("FAIL single_byte got=%h exp=%h", o9, e9); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
    task automatic test_back_to_back();
        logic [1:0] g, dn, eg; logic [31:0] d, ed; logic e; logic [3:0] bc; logic [8:0] o9, e9; int db0;
        do_reset();
        db0 = dbl_cnt;
        bus.data0 = 32'h11223344; bus.data1 = 32'h55667788; bus.req0 = 1; bus.req1 = 1;
        for (int j = 0; j < 3; j++) begin
            do_job(2, 0, j == 2, g, d, dn, e, bc);
            eg = (j == 1) ? 2'b10 : 2'b01;
            ed = (j == 1) ? 32'h55667788 : 32'h11223344;
            total++; if (g !== eg) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", j, g, eg); end
            total++; if (d !== ed) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", j, d, ed); end
            total++; if (dn !== eg || bc !== 4'd2) begin bad++; $display("FAIL rr_done%0d got=%b/%0d exp=%b/2", j, dn, bc, eg); end
        end
        total++; if (dbl_cnt != db0) begin bad++; $display("FAIL rr_double got=%0d exp=0", dbl_cnt - db0); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_nbytes got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e9 = exp_q.pop_front(); o9 = obs_q.pop_front();
            total++; if (o9 !== e9) begin bad++; $display("FAIL rr_byte got=%h exp=%h", o9, e9); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
    task automatic test_timeout();
        int k, d0;
        do_reset();
        d0 = done_cnt;
        bus.data1 = 32'hCAFE0001; bus.req1 = 1;
        k = 0;
        while (bus.gnt == 2'b00 && k < 20) begin @(negedge clk); k++; end
        total++; if (bus.gnt !== 2'b10 || bus.enc_start !== 1'b1) begin bad++; $display("FAIL tmo_gnt got=%b/%b exp=10/1", bus.gnt, bus.enc_start); end
        @(posedge clk); #1 bus.req1 = 0;
        k = 1;
        @(negedge clk);
        while (!bus.err && k < 100) begin @(negedge clk); k++; end
        total++; if (k != 64) begin bad++; $display("FAIL tmo_latency got=%0d exp=64", k); end
        total++; if (bus.err_src !== 1'b1) begin bad++; $display("FAIL tmo_src got=%b exp=1", bus.err_src); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL tmo_done got=%0d exp=0", done_cnt - d0); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b/%b exp=0/0", bus.busy, bus.err); end
        obs_q.delete(); exp_q.delete();
    endtask
    task automatic test_overflow();
        logic [1:0] g, dn; logic [31:0] d; logic e; logic [3:0] bc; logic [8:0] o9, e9;
        do_reset();
        bus.data0 = 32'h01020304; bus.req0 = 1;
        do_job(3, 0, 1, g, d, dn, e, bc);
        total++; if (dn !== 2'b01 || bc !== 4'd3) begin bad++; $display("FAIL ovf_pre got=%b/%0d exp=01/3", dn, bc); end
        bus.req0 = 1;
        do_job(9, 0, 1, g, d, dn, e, bc);
        total++; if (e !== 1'b1 || dn !== 2'b00) begin bad++; $display("FAIL ovf_err got=%b/%b exp=1/00", e, dn); end
        total++; if (bc !== 4'd3) begin bad++; $display("FAIL ovf_count got=%0d exp=3", bc); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_nbytes got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e9 = exp_q.pop_front(); o9 = obs_q.pop_front();
            total++; if (o9 !== e9) begin bad++; $display("FAIL ovf_byte got=%h exp=%h", o9, e9); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
    task automatic test_same_cycle();
        logic [1:0] g, dn; logic [31:0] d; logic e; logic [3:0] bc; logic [8:0] o9, e9;
        do_reset();
        bus.data0 = 32'h7F7F0101; bus.req0 = 1;
        do_job(5, 1, 1, g, d, dn, e, bc);
        total++; if (dn !== 2'b01 || bc !== 4'd5) begin bad++; $display("FAIL same_done got=%b/%0d exp=01/5", dn, bc); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL same_nbytes got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e9 = exp_q.pop_front(); o9 = obs_q.pop_front();
            total++; if (o9 !== e9) begin bad++; $display("FAIL same_byte got=%h exp=%h", o9, e9); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
    task automatic test_reset_in_run();
        logic [1:0] g, dn; logic [31:0] d; logic e; logic [3:0] bc; logic [8:0] o9, e9; logic [7:0] b;
        logic [53:0] snap; int k;
        do_reset();
        bus.data0 = 32'h0A0B0C0D; bus.data1 = 32'h12345678; bus.req0 = 1;
        k = 0;
        while (bus.gnt == 2'b00 && k < 20) begin @(negedge clk); k++; end
        total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL rir_gnt got=%b exp=01", bus.gnt); end
        @(posedge clk); #1 bus.enc_ready = 0; bus.req0 = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            b = 8'($urandom_range(0, 255));
            bus.enc_bvalid = 1; bus.enc_byte = b;
            exp_q.push_back({1'b0, b});
        end
        @(posedge clk); #1 bus.enc_bvalid = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); @(negedge clk);
        snap = {bus.gnt, bus.done, bus.err, bus.err_src, bus.enc_start, bus.enc_data, bus.out_byte,
                bus.out_valid, bus.out_src, bus.byte_count, bus.busy};
        total++; if (snap !== 54'h0) begin bad++; $display("FAIL rir_outputs got=%h exp=0", snap); end
        @(posedge clk); #1 rst_n = 1; bus.enc_ready = 1; bus.req1 = 1;
        do_job(2, 0, 1, g, d, dn, e, bc);
        total++; if (g !== 2'b10 || d !== 32'h12345678) begin bad++; $display("FAIL rir_regnt got=%b/%h exp=10/12345678", g, d); end
        total++; if (dn !== 2'b10 || bc !== 4'd2) begin bad++; $display("FAIL rir_done got=%b/%0d exp=10/2", dn, bc); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rir_nbytes got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e9 = exp_q.pop_front(); o9 = obs_q.pop_front();
            total++; if (o9 !== e9) begin bad++; $display("FAIL rir_byte got=%h exp=%h", o9, e9); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
    initial begin
        bus.data0 = 0; bus.data1 = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_same_cycle();
        test_reset_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
